// File: rtl/log_capture_ctrl_pkg.sv
// Shared definitions for the log capture controller.
//   - default widths for the BRAM address, sample word and decimation setting
//   - FSM state encoding (3-bit), visible on the top-level debug port
//   - fixed host read latency (request cycle to valid cycle)
package log_capture_ctrl_pkg;

  localparam int LOG_ADDR_W  = 15;
  localparam int LOG_DATA_W  = 16;
  localparam int LOG_DECIM_W = 8;
  localparam int LOG_RD_W    = 32;
  localparam int LOG_RD_LAT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_FULL     = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4
  } state_t;

  // Idle/full are the only states that accept host commands.
  function automatic logic accepts_cmd(state_t s);
    return (s == ST_IDLE) || (s == ST_FULL);
  endfunction

endpackage

// File: rtl/log_capture_ctrl_decimator.sv
// Sample decimator for the log capture controller.
// Keeps 1 of every (decim+1) strobed samples, starting with the first strobe
// after a load. The decimation setting is captured on load and held for the
// whole capture, so later changes on the input have no effect.
// Ports:
//   clk, i_rst  clock and synchronous active-high reset
//   load        restart: counter to 0, latch decim
//   decim       decimation setting (keep 1 of decim+1)
//   strobe      a candidate sample is present this cycle
//   take        this strobe is to be written (combinational)
module log_capture_ctrl_decimator #(
  parameter int DECIM_W = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               load,
  input  logic [DECIM_W-1:0] decim,
  input  logic               strobe,
  output logic               take
);

  logic [DECIM_W-1:0] dcnt_q;
  logic [DECIM_W-1:0] decim_q;

  assign take = strobe && (dcnt_q == '0);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      dcnt_q  <= '0;
      decim_q <= '0;
    end else if (load) begin
      dcnt_q  <= '0;
      decim_q <= decim;
    end else if (strobe) begin
      dcnt_q <= (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_W'(1);
    end
  end

endmodule

// File: rtl/log_capture_ctrl.sv
// Log capture controller: sequences one-shot sample capture into a
// single-port BRAM and arbitrates host readback on the same port.
//
// Host read protocol: i_rd_req is a one-cycle request with i_rd_addr sampled
// in the same cycle. It is accepted only in IDLE or FULL and never queued;
// an accepted request in cycle N produces a single-cycle o_rd_valid in cycle
// N+2 with o_rd_data valid alongside. o_rd_data then holds that word until the
// next read completes. There is no back-pressure.
//
// Ports:
//   clk, i_rst        clock, synchronous active-high reset
//   i_arm, i_abort    start a capture from address 0 / stop it (abort wins)
//   i_decim           keep 1 of every (i_decim+1) valid samples, taken at arm
//   i_smp_valid/data  decimated I/Q sample stream from the filter chain
//   i_rd_req/addr     host read request
//   o_rd_valid/data   host read response (zero-extended to 32 bits)
//   o_busy            capture or read in progress
//   o_mem_full        BRAM filled by the last capture
//   o_wr_count        samples written in the current/last capture
//   o_bram_*          BRAM port (en, we, addr, wdata), i_bram_rdata 1-cycle latency
//   o_dbg_state       current FSM state
module log_capture_ctrl
  import log_capture_ctrl_pkg::*;
#(
  parameter int ADDR_W  = LOG_ADDR_W,
  parameter int DATA_W  = LOG_DATA_W,
  parameter int DECIM_W = LOG_DECIM_W
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_arm,
  input  logic                i_abort,
  input  logic [DECIM_W-1:0]  i_decim,
  input  logic                i_smp_valid,
  input  logic [DATA_W-1:0]   i_smp_data,
  input  logic                i_rd_req,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic                o_rd_valid,
  output logic [LOG_RD_W-1:0] o_rd_data,
  output logic                o_busy,
  output logic                o_mem_full,
  output logic [ADDR_W:0]     o_wr_count,
  output logic                o_bram_en,
  output logic                o_bram_we,
  output logic [ADDR_W-1:0]   o_bram_addr,
  output logic [DATA_W-1:0]   o_bram_wdata,
  input  logic [DATA_W-1:0]   i_bram_rdata,
  output logic [2:0]          o_dbg_state
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W:0]     wr_count_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_home_full_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                arm_ok;
  logic                rd_ok;
  logic                smp_strobe;
  logic                take;

  // Abort outranks arm; arm outranks a same-cycle read.
  assign arm_ok     = accepts_cmd(state_q) && i_arm && !i_abort;
  assign rd_ok      = accepts_cmd(state_q) && i_rd_req && !i_arm;
  // A sample arriving with abort is dropped: the capture is being stopped.
  assign smp_strobe = (state_q == ST_CAPTURE) && i_smp_valid && !i_abort;

  log_capture_ctrl_decimator #(
    .DECIM_W (DECIM_W)
  ) u_decim (
    .clk    (clk),
    .i_rst  (i_rst),
    .load   (arm_ok),
    .decim  (i_decim),
    .strobe (smp_strobe),
    .take   (take)
  );

  always_comb begin
    state_d      = state_q;
    o_bram_en    = 1'b0;
    o_bram_we    = 1'b0;
    o_bram_addr  = '0;
    o_bram_wdata = '0;
    case (state_q)
      ST_IDLE, ST_FULL: begin
        if (arm_ok)     state_d = ST_CAPTURE;
        else if (rd_ok) state_d = ST_RD_ISSUE;
      end
      ST_CAPTURE: begin
        if (take) begin
          o_bram_en    = 1'b1;
          o_bram_we    = 1'b1;
          o_bram_addr  = wr_addr_q;
          o_bram_wdata = i_smp_data;
        end
        // No wrap: the write to the last address ends the capture.
        if (i_abort)                       state_d = ST_IDLE;
        else if (take && (&wr_addr_q))     state_d = ST_FULL;
      end
      ST_RD_ISSUE: begin
        o_bram_en   = 1'b1;
        o_bram_addr = rd_addr_q;
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_d = rd_home_full_q ? ST_FULL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      wr_addr_q      <= '0;
      wr_count_q     <= '0;
      rd_addr_q      <= '0;
      rd_home_full_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q <= state_d;
      if (arm_ok) begin
        wr_addr_q  <= '0;
        wr_count_q <= '0;
      end else if (take) begin
        wr_addr_q  <= wr_addr_q + ADDR_W'(1);
        wr_count_q <= wr_count_q + (ADDR_W+1)'(1);
      end
      if (rd_ok) begin
        rd_addr_q      <= i_rd_addr;
        rd_home_full_q <= (state_q == ST_FULL);
      end
      if (state_q == ST_RD_WAIT) rd_data_q <= i_bram_rdata;
    end
  end

  // The BRAM word is presented directly in RD_WAIT so valid and data line up
  // at N+2; the register only holds it afterwards. Reset suppresses the pulse.
  assign o_rd_valid  = (state_q == ST_RD_WAIT) && !i_rst;
  assign o_rd_data   = LOG_RD_W'((state_q == ST_RD_WAIT) ? i_bram_rdata : rd_data_q);
  assign o_busy      = (state_q == ST_CAPTURE) || (state_q == ST_RD_ISSUE) ||
                       (state_q == ST_RD_WAIT);
  assign o_mem_full  = (state_q == ST_FULL);
  assign o_wr_count  = wr_count_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_log_capture_ctrl.sv
module tb_log_capture_ctrl;
  import log_capture_ctrl_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DCW   = 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_arm = 1'b0, i_abort = 1'b0;
  logic [DCW-1:0] i_decim = '0;
  logic           i_smp_valid = 1'b0;
  logic [DW-1:0]  i_smp_data = '0;
  logic           i_rd_req = 1'b0;
  logic [AW-1:0]  i_rd_addr = '0;
  logic           o_rd_valid;
  logic [31:0]    o_rd_data;
  logic           o_busy, o_mem_full;
  logic [AW:0]    o_wr_count;
  logic           o_bram_en, o_bram_we;
  logic [AW-1:0]  o_bram_addr;
  logic [DW-1:0]  o_bram_wdata;
  logic [DW-1:0]  i_bram_rdata = '0;
  logic [2:0]     o_dbg_state;

  always #5 clk = ~clk;

  log_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DECIM_W(DCW)) dut (
    .clk(clk), .i_rst(i_rst), .i_arm(i_arm), .i_abort(i_abort), .i_decim(i_decim),
    .i_smp_valid(i_smp_valid), .i_smp_data(i_smp_data), .i_rd_req(i_rd_req),
    .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_busy(o_busy), .o_mem_full(o_mem_full), .o_wr_count(o_wr_count),
    .o_bram_en(o_bram_en), .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
    .o_bram_wdata(o_bram_wdata), .i_bram_rdata(i_bram_rdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- BRAM behavioural stand-in ----------------
  logic          tb_init = 1'b1;
  logic [DW-1:0] bram_mem [DEPTH];

  function automatic logic [DW-1:0] init_word(int i);
    return 16'hA000 + 16'(i);
  endfunction

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < DEPTH; i++) bram_mem[i] <= init_word(i);
    end else if (o_bram_en && o_bram_we) begin
      bram_mem[o_bram_addr] <= o_bram_wdata;
    end
    if (o_bram_en && !o_bram_we) i_bram_rdata <= bram_mem[o_bram_addr];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Described as a capture session (how many valid samples seen, how many
  // kept) plus a read in flight counted by age since acceptance.
  logic          m_capturing = 1'b0;
  logic          m_full = 1'b0;
  int            m_rd_age = -1;
  logic [AW-1:0] m_rd_addr = '0;
  int            m_valids = 0;
  int            m_written = 0;
  int            m_decim = 0;
  logic [31:0]   m_last_rd = '0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [31:0]   exp_q [$];   // expected read words, in issue order

  always @(negedge clk) begin
    logic        e_en, e_we, e_valid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [31:0] e_rdata;
    if (tb_init) for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    if (i_rst) begin
      chk("rd_valid_in_reset", 32'(o_rd_valid), 32'd0);
      m_capturing = 1'b0; m_full = 1'b0; m_rd_age = -1; m_valids = 0;
      m_written = 0; m_decim = 0; m_last_rd = '0;
      exp_q.delete();
    end else begin
      e_en = 1'b0; e_we = 1'b0; e_valid = 1'b0; e_addr = '0; e_wd = '0;
      e_rdata = m_last_rd;
      if (m_rd_age == 0) begin
        e_en = 1'b1; e_addr = m_rd_addr;
      end else if (m_rd_age == 1) begin
        e_valid = 1'b1; e_rdata = exp_q.pop_front();
      end else if (m_capturing && i_smp_valid && !i_abort &&
                   (m_valids % (m_decim + 1)) == 0) begin
        e_en = 1'b1; e_we = 1'b1; e_addr = AW'(m_written); e_wd = i_smp_data;
      end
      chk("bram_en", 32'(o_bram_en), 32'(e_en));
      if (e_en) begin
        chk("bram_we", 32'(o_bram_we), 32'(e_we));
        chk("bram_addr", 32'(o_bram_addr), 32'(e_addr));
        if (e_we) chk("bram_wdata", 32'(o_bram_wdata), 32'(e_wd));
      end
      chk("rd_valid", 32'(o_rd_valid), 32'(e_valid));
      chk("rd_data", o_rd_data, e_rdata);
      chk("busy", 32'(o_busy), 32'(m_capturing || m_rd_age >= 0));
      chk("mem_full", 32'(o_mem_full), 32'(m_full && m_rd_age < 0));
      chk("wr_count", 32'(o_wr_count), 32'(m_written));
      // advance the model by one clock
      if (m_rd_age == 1) begin
        m_last_rd = e_rdata; m_rd_age = -1;
      end else if (m_rd_age == 0) begin
        m_rd_age = 1;
      end else if (m_capturing) begin
        if (i_abort) m_capturing = 1'b0;
        else if (i_smp_valid) begin
          if (e_we) begin
            ref_mem[m_written] = i_smp_data;
            m_written++;
            if (m_written == DEPTH) begin m_capturing = 1'b0; m_full = 1'b1; end
          end
          m_valids++;
        end
      end else if (i_arm && !i_abort) begin
        m_capturing = 1'b1; m_full = 1'b0; m_valids = 0; m_written = 0;
        m_decim = int'(i_decim);
      end else if (i_rd_req && !i_arm) begin
        m_rd_age = 0; m_rd_addr = i_rd_addr;
        exp_q.push_back({16'h0, ref_mem[i_rd_addr]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One call = one clock cycle of stimulus; returns #1 after the next edge.
  task automatic drive(input logic arm, input logic abort, input logic [DCW-1:0] dec,
                       input logic v, input logic [DW-1:0] d,
                       input logic rq, input logic [AW-1:0] ra);
    i_arm = arm; i_abort = abort; i_decim = dec; i_smp_valid = v;
    i_smp_data = d; i_rd_req = rq; i_rd_addr = ra;
    @(posedge clk); #1;
    i_arm = 1'b0; i_abort = 1'b0; i_smp_valid = 1'b0; i_rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, i_decim, 0, '0, 0, '0);
  endtask

  task automatic fill_dec0(input logic [DW-1:0] base);
    drive(1, 0, 8'd0, 0, '0, 0, '0);
    for (int k = 0; k < DEPTH; k++) drive(0, 0, 8'd0, 1, base + DW'(k), 0, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1; tb_init = 1'b0; i_rst = 1'b0;

    // reset state
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_full", 32'(o_mem_full), 32'd0);
    chk("rst_count", 32'(o_wr_count), 32'd0);
    chk("rst_rdata", o_rd_data, 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));

    // read before any capture returns the BRAM contents
    drive(0, 0, 8'd0, 0, '0, 1, 4'd3);
    idle(LOG_RD_LAT - 1);
    chk("pre_rd_valid", 32'(o_rd_valid), 32'd1);
    chk("pre_rd_data", o_rd_data, 32'h0000A003);
    idle(1);

    // decim 0: 16 samples fill the memory
    fill_dec0(16'h0100);
    chk("t1_full", 32'(o_mem_full), 32'd1);
    chk("t1_count", 32'(o_wr_count), 32'd16);
    drive(0, 0, 8'd0, 0, '0, 1, 4'd5);
    chk("t1_rd_n1", 32'(o_rd_valid), 32'd0);
    idle(1);
    chk("t1_rd_n2", 32'(o_rd_valid), 32'd1);
    chk("t1_rd_data", o_rd_data, 32'h00000105);
    idle(1);
    chk("t1_back_full", 32'(o_mem_full), 32'd1);
    chk("t1_rd_hold", o_rd_data, 32'h00000105);

    // decim 2; i_decim changed after arm must not matter
    drive(1, 0, 8'd2, 0, '0, 0, '0);
    for (int k = 0; k < 48; k++) begin
      drive(0, 0, 8'd7, 1, 16'h0200 + 16'(k), 0, '0);
      if (k == 44) chk("t2_not_full_45", 32'(o_mem_full), 32'd0);
      if (k == 45) chk("t2_full_46", 32'(o_mem_full), 32'd1);
    end
    chk("t2_count", 32'(o_wr_count), 32'd16);
    drive(0, 0, 8'd0, 0, '0, 1, 4'd15);
    idle(1);
    chk("t2_rd15", o_rd_data, 32'h0000022D);
    idle(1);

    // abort after 7 samples
    drive(1, 0, 8'd0, 0, '0, 0, '0);
    for (int k = 0; k < 7; k++) drive(0, 0, 8'd0, 1, 16'h0300 + 16'(k), 0, '0);
    drive(0, 1, 8'd0, 0, '0, 0, '0);
    chk("t3_state", 32'(o_dbg_state), 32'(ST_IDLE));
    chk("t3_count", 32'(o_wr_count), 32'd7);
    chk("t3_full", 32'(o_mem_full), 32'd0);
    for (int k = 0; k < 3; k++) drive(0, 0, 8'd0, 1, 16'h0400, 0, '0);
    chk("t3_count_hold", 32'(o_wr_count), 32'd7);

    // arm + read in FULL: arm wins; read during capture ignored
    fill_dec0(16'h0500);
    drive(1, 0, 8'd0, 0, '0, 1, 4'd2);
    chk("t4_state", 32'(o_dbg_state), 32'(ST_CAPTURE));
    drive(0, 0, 8'd0, 0, '0, 1, 4'd2);
    idle(1);
    chk("t4_no_valid", 32'(o_rd_valid), 32'd0);
    drive(0, 1, 8'd0, 0, '0, 0, '0);

    // reset during RD_WAIT
    drive(0, 0, 8'd0, 0, '0, 1, 4'd4);
    idle(1);
    chk("t5_in_wait", 32'(o_dbg_state), 32'(ST_RD_WAIT));
    i_rst = 1'b1;
    #1;
    chk("t5_valid_blocked", 32'(o_rd_valid), 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    chk("t5_state", 32'(o_dbg_state), 32'(ST_IDLE));
    chk("t5_outs", {o_rd_data[15:0], 7'd0, o_rd_valid, o_busy, o_mem_full, o_bram_en,
                    o_wr_count}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      i_rst = ($urandom_range(0, 599) == 0);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0,
            ($urandom_range(0, 3) == 0) ? DCW'($urandom_range(0, 255)) : DCW'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 6, DW'($urandom), $urandom_range(0, 7) == 0,
            AW'($urandom_range(0, DEPTH - 1)));
      i_rst = 1'b0;
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
